// File: rtl/qpp_pkg.sv
// -----------------------------------------------------------------------------
// qpp_pkg
// Shared definitions for the QPP interleaver index generator:
//   - qpp_state_e : controller state encoding (IDLE / INIT / RUN)
//   - cfg_chk_e   : result code of the configuration validation
// -----------------------------------------------------------------------------
package qpp_pkg;

  // Controller states. Encoding is fixed so the debug state output is stable
  // across builds and easy to decode in waveforms.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } qpp_state_e;

  // Configuration validation result. Anything other than CFG_OK rejects the
  // cfg beat and raises the one-cycle error pulse.
  typedef enum logic [2:0] {
    CFG_OK            = 3'd0,
    CFG_ERR_K_ZERO    = 3'd1,
    CFG_ERR_F1_RANGE  = 3'd2,
    CFG_ERR_F2_RANGE  = 3'd3,
    CFG_ERR_NBLK_ZERO = 3'd4
  } cfg_chk_e;

endpackage : qpp_pkg

// File: rtl/qpp_index_gen_mod_add.sv
// -----------------------------------------------------------------------------
// mod_add
// Combinational modular adder: sum_o = (a_i + b_i) mod k_i.
// Both operands must already be reduced (a_i < k_i, b_i < k_i), so a single
// conditional subtraction is enough. The sum is formed one bit wider than the
// operands so that K close to 2^DATA_WIDTH cannot overflow.
//
// Ports:
//   a_i   [DATA_WIDTH-1:0]  first operand  (< k_i)
//   b_i   [DATA_WIDTH-1:0]  second operand (< k_i)
//   k_i   [DATA_WIDTH-1:0]  modulus
//   sum_o [DATA_WIDTH-1:0]  (a_i + b_i) mod k_i
// -----------------------------------------------------------------------------
module mod_add #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [DATA_WIDTH-1:0] k_i,
  output logic [DATA_WIDTH-1:0] sum_o
);

  logic [DATA_WIDTH:0] sum_full;
  logic [DATA_WIDTH:0] sum_red;
  logic [DATA_WIDTH:0] k_ext;

  assign k_ext    = {1'b0, k_i};
  assign sum_full = {1'b0, a_i} + {1'b0, b_i};
  assign sum_red  = sum_full - k_ext;
  assign sum_o    = (sum_full >= k_ext) ? sum_red[DATA_WIDTH-1:0]
                                        : sum_full[DATA_WIDTH-1:0];

endmodule : mod_add

// File: rtl/qpp_index_gen.sv
// -----------------------------------------------------------------------------
// qpp_index_gen
// Successor QPP interleaver index generator: emits ind(i) = (f1*i + f2*i^2)
// mod K for i = 0..K-1, repeated nblk times, one index per clock on an
// AXI-Stream master. The quadratic is evaluated recursively:
//   pi(i+1) = pi(i) + g(i)        (mod K)
//   g(i+1)  = g(i)  + 2*f2        (mod K),  g(0) = f1 + f2 (mod K)
// so only modular adders are needed.
//
// Handshake semantics (both streams): a beat transfers on a rising aclk edge
// where tvalid and tready are both high. Once the master raises tvalid it
// keeps tvalid and all payload fields stable until the transfer happens;
// tvalid never depends combinationally on tready.
//
// Ports:
//   aclk, aresetn         clock, asynchronous active-low reset
//   s_axis_cfg_*          cfg slave stream (f1, f2, K, nblk); ready in IDLE
//   i_abort               synchronous abort, forces IDLE on the next edge
//   m_axis_ind_tdata      interleaved index ind(i)
//   m_axis_ind_tid        natural index i
//   m_axis_ind_tuser      start of block (i == 0)
//   m_axis_ind_tlast      end of block   (i == K-1)
//   m_axis_ind_tvalid/_tready  index master stream handshake
//   o_cfg_err             one-cycle pulse when a cfg beat is rejected
//   o_busy                high while not IDLE
//   o_dbg_state           current controller state (qpp_state_e encoding)
// -----------------------------------------------------------------------------
module qpp_index_gen
  import qpp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_cfg_f1,
  input  logic [DATA_WIDTH-1:0] s_axis_cfg_f2,
  input  logic [DATA_WIDTH-1:0] s_axis_cfg_k,
  input  logic [CNT_WIDTH-1:0]  s_axis_cfg_nblk,
  input  logic                  s_axis_cfg_tvalid,
  output logic                  s_axis_cfg_tready,
  input  logic                  i_abort,
  output logic [DATA_WIDTH-1:0] m_axis_ind_tdata,
  output logic [DATA_WIDTH-1:0] m_axis_ind_tid,
  output logic                  m_axis_ind_tuser,
  output logic                  m_axis_ind_tlast,
  output logic                  m_axis_ind_tvalid,
  input  logic                  m_axis_ind_tready,
  output logic                  o_cfg_err,
  output logic                  o_busy,
  output logic [1:0]            o_dbg_state
);

  localparam logic [DATA_WIDTH-1:0] ONE_D = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  ONE_C = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  qpp_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] f1_q,   f1_d;
  logic [DATA_WIDTH-1:0] f2_q,   f2_d;
  logic [DATA_WIDTH-1:0] k_q,    k_d;
  logic [CNT_WIDTH-1:0]  nblk_q, nblk_d;
  logic [DATA_WIDTH-1:0] pi_q,   pi_d;
  logic [DATA_WIDTH-1:0] g_q,    g_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;
  logic [DATA_WIDTH-1:0] i_q,    i_d;
  logic [CNT_WIDTH-1:0]  blk_q,  blk_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  cfg_rdy_q, cfg_rdy_d;

  cfg_chk_e              cfg_chk;
  logic                  cfg_fire;
  logic                  ind_fire;
  logic                  last_idx;
  logic                  last_blk;

  logic [DATA_WIDTH-1:0] pi_sum;
  logic [DATA_WIDTH-1:0] g_sum;
  logic [DATA_WIDTH-1:0] g0_sum;
  logic [DATA_WIDTH-1:0] g_add_a;
  logic [DATA_WIDTH-1:0] g_add_b;

  // ---------------------------------------------------------------------------
  // Modular adders
  // ---------------------------------------------------------------------------
  // pi + g : next interleaved index.
  mod_add #(.DATA_WIDTH(DATA_WIDTH)) u_add_pi (
    .a_i   (pi_q),
    .b_i   (g_q),
    .k_i   (k_q),
    .sum_o (pi_sum)
  );

  // g + step in RUN. The g adder is otherwise idle during INIT, so it is
  // borrowed there to compute step = (f2 + f2) mod K.
  assign g_add_a = (state_q == ST_INIT) ? f2_q : g_q;
  assign g_add_b = (state_q == ST_INIT) ? f2_q : step_q;

  mod_add #(.DATA_WIDTH(DATA_WIDTH)) u_add_g (
    .a_i   (g_add_a),
    .b_i   (g_add_b),
    .k_i   (k_q),
    .sum_o (g_sum)
  );

  // (f1 + f2) mod K : initial g, used in INIT and on every block restart.
  mod_add #(.DATA_WIDTH(DATA_WIDTH)) u_add_init (
    .a_i   (f1_q),
    .b_i   (f2_q),
    .k_i   (k_q),
    .sum_o (g0_sum)
  );

  // ---------------------------------------------------------------------------
  // Cfg validation on the incoming (not yet latched) beat
  // ---------------------------------------------------------------------------
  always_comb begin
    cfg_chk = CFG_OK;
    if (s_axis_cfg_k == '0) begin
      cfg_chk = CFG_ERR_K_ZERO;
    end else if (s_axis_cfg_f1 >= s_axis_cfg_k) begin
      cfg_chk = CFG_ERR_F1_RANGE;
    end else if (s_axis_cfg_f2 >= s_axis_cfg_k) begin
      cfg_chk = CFG_ERR_F2_RANGE;
    end else if (s_axis_cfg_nblk == '0) begin
      cfg_chk = CFG_ERR_NBLK_ZERO;
    end
  end

  // Abort masks tready so an abort cycle can never complete a cfg handshake.
  assign s_axis_cfg_tready = cfg_rdy_q & ~i_abort;
  assign cfg_fire          = s_axis_cfg_tvalid & s_axis_cfg_tready;
  assign ind_fire          = (state_q == ST_RUN) & m_axis_ind_tready;
  assign last_idx          = (i_q == (k_q - ONE_D));
  assign last_blk          = (blk_q == (nblk_q - ONE_C));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    f1_d      = f1_q;
    f2_d      = f2_q;
    k_d       = k_q;
    nblk_d    = nblk_q;
    pi_d      = pi_q;
    g_d       = g_q;
    step_d    = step_q;
    i_d       = i_q;
    blk_d     = blk_q;
    cfg_err_d = 1'b0;

    if (i_abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cfg_fire) begin
            f1_d   = s_axis_cfg_f1;
            f2_d   = s_axis_cfg_f2;
            k_d    = s_axis_cfg_k;
            nblk_d = s_axis_cfg_nblk;
            if (cfg_chk != CFG_OK) begin
              cfg_err_d = 1'b1;
            end else begin
              state_d = ST_INIT;
            end
          end
        end

        ST_INIT: begin
          g_d     = g0_sum;
          step_d  = g_sum;
          pi_d    = '0;
          i_d     = '0;
          blk_d   = '0;
          state_d = ST_RUN;
        end

        ST_RUN: begin
          if (ind_fire) begin
            if (!last_idx) begin
              pi_d = pi_sum;
              g_d  = g_sum;
              i_d  = i_q + ONE_D;
            end else if (!last_blk) begin
              // Restart the recursion in place so the next block follows
              // without an idle cycle.
              blk_d = blk_q + ONE_C;
              pi_d  = '0;
              i_d   = '0;
              g_d   = g0_sum;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Registered so tready stays low while reset is asserted and rises on the
  // first edge after release.
  assign cfg_rdy_d = (state_d == ST_IDLE);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      f1_q      <= '0;
      f2_q      <= '0;
      k_q       <= '0;
      nblk_q    <= '0;
      pi_q      <= '0;
      g_q       <= '0;
      step_q    <= '0;
      i_q       <= '0;
      blk_q     <= '0;
      cfg_err_q <= 1'b0;
      cfg_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      f1_q      <= f1_d;
      f2_q      <= f2_d;
      k_q       <= k_d;
      nblk_q    <= nblk_d;
      pi_q      <= pi_d;
      g_q       <= g_d;
      step_q    <= step_d;
      i_q       <= i_d;
      blk_q     <= blk_d;
      cfg_err_q <= cfg_err_d;
      cfg_rdy_q <= cfg_rdy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: payload comes straight from registers, so it is stable for as
  // long as the beat is stalled.
  // ---------------------------------------------------------------------------
  assign m_axis_ind_tvalid = (state_q == ST_RUN);
  assign m_axis_ind_tdata  = pi_q;
  assign m_axis_ind_tid    = i_q;
  assign m_axis_ind_tuser  = (state_q == ST_RUN) & (i_q == '0);
  assign m_axis_ind_tlast  = (state_q == ST_RUN) & last_idx;
  assign o_cfg_err         = cfg_err_q;
  assign o_busy            = (state_q != ST_IDLE);
  assign o_dbg_state       = state_q;

endmodule : qpp_index_gen

// File: tb/tb_qpp_index_gen.sv
// -----------------------------------------------------------------------------
// tb_qpp_index_gen
// Directed bench for qpp_index_gen: golden quadratic model, expected-value
// queue per run, stall-stability checks, invalid cfg, abort and reset cases.
// -----------------------------------------------------------------------------
module tb_qpp_index_gen;

  localparam int DW = 32;
  localparam int CW = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          aclk = 1'b0;
  logic          aresetn;
  always #5 aclk = ~aclk;

  logic [DW-1:0] cfg_f1, cfg_f2, cfg_k;
  logic [CW-1:0] cfg_nblk;
  logic          cfg_tvalid, cfg_tready;
  logic          abort;
  logic [DW-1:0] m_tdata, m_tid;
  logic          m_tuser, m_tlast, m_tvalid, m_tready;
  logic          cfg_err, busy;
  logic [1:0]    dbg_state;

  qpp_index_gen #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .s_axis_cfg_f1     (cfg_f1),
    .s_axis_cfg_f2     (cfg_f2),
    .s_axis_cfg_k      (cfg_k),
    .s_axis_cfg_nblk   (cfg_nblk),
    .s_axis_cfg_tvalid (cfg_tvalid),
    .s_axis_cfg_tready (cfg_tready),
    .i_abort           (abort),
    .m_axis_ind_tdata  (m_tdata),
    .m_axis_ind_tid    (m_tid),
    .m_axis_ind_tuser  (m_tuser),
    .m_axis_ind_tlast  (m_tlast),
    .m_axis_ind_tvalid (m_tvalid),
    .m_axis_ind_tready (m_tready),
    .o_cfg_err         (cfg_err),
    .o_busy            (busy),
    .o_dbg_state       (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] exp_q[$];
  // First indices for K=40, f1=3, f2=10, worked out by hand.
  logic [DW-1:0] hand_tbl [8] = '{32'd0, 32'd13, 32'd6, 32'd19,
                                  32'd12, 32'd25, 32'd18, 32'd31};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] golden(input longint unsigned f1, input longint unsigned f2,
                                           input longint unsigned k, input longint unsigned i);
    longint unsigned r;
    r = (f1 * i + f2 * i * i) % k;
    return r[DW-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic send_cfg(input logic [DW-1:0] f1, input logic [DW-1:0] f2,
                          input logic [DW-1:0] k, input logic [CW-1:0] nblk);
    int w;
    w = 0;
    @(negedge aclk);
    cfg_f1     = f1;
    cfg_f2     = f2;
    cfg_k      = k;
    cfg_nblk   = nblk;
    cfg_tvalid = 1'b1;
    while (!cfg_tready && w < 50) begin
      @(negedge aclk);
      w++;
    end
    chk("cfg_ready_wait", (w < 50), 1);
    @(negedge aclk);
    cfg_tvalid = 1'b0;
  endtask

  // Consume nbeats output beats; the caller has just returned from send_cfg,
  // so the first negedge here is the first cycle tvalid must be high.
  task automatic collect(input logic [DW-1:0] k, input logic [DW-1:0] f1,
                         input logic [DW-1:0] f2, input int nbeats, input bit rnd);
    int            beats, cyc;
    bit            stall;
    logic [DW-1:0] p_data, p_id;
    logic          p_user, p_last;
    longint unsigned idx;
    beats = 0; cyc = 0; stall = 0;
    p_data = '0; p_id = '0; p_user = 0; p_last = 0;
    exp_q.delete();
    for (int b = 0; b < nbeats; b++)
      exp_q.push_back(golden(f1, f2, k, longint'(b) % longint'(k)));
    while (beats < nbeats && cyc < nbeats * 4 + 20) begin
      @(negedge aclk);
      cyc++;
      chk("tvalid_run", m_tvalid, 1);
      if (stall) begin
        chk("stall_tdata", m_tdata, p_data);
        chk("stall_tid",   m_tid,   p_id);
        chk("stall_tuser", m_tuser, p_user);
        chk("stall_tlast", m_tlast, p_last);
      end
      m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_tvalid && m_tready) begin
        idx = longint'(beats) % longint'(k);
        chk("tdata", m_tdata, exp_q.pop_front());
        chk("tid",   m_tid,   idx);
        chk("tuser", m_tuser, (idx == 0));
        chk("tlast", m_tlast, (idx == longint'(k) - 1));
        if (k == 40 && f1 == 3 && f2 == 10 && idx < 8)
          chk("hand_tdata", m_tdata, hand_tbl[idx]);
        beats++;
      end
      stall  = m_tvalid && !m_tready;
      p_data = m_tdata; p_id = m_tid; p_user = m_tuser; p_last = m_tlast;
    end
    chk("beats_done", beats, nbeats);
  endtask

  task automatic check_init;
    chk("init_tvalid", m_tvalid, 0);
    chk("init_busy",   busy, 1);
    chk("init_tready", cfg_tready, 0);
    chk("init_state",  dbg_state, 1);
  endtask

  task automatic check_idle_after;
    @(negedge aclk);
    chk("end_tvalid", m_tvalid, 0);
    chk("end_busy",   busy, 0);
    chk("end_tready", cfg_tready, 1);
  endtask

  task automatic check_bad(input string tag, input logic [DW-1:0] f1, input logic [DW-1:0] f2,
                           input logic [DW-1:0] k, input logic [CW-1:0] nblk);
    send_cfg(f1, f2, k, nblk);
    chk({tag, "_err"},    cfg_err, 1);
    chk({tag, "_tvalid"}, m_tvalid, 0);
    chk({tag, "_tready"}, cfg_tready, 1);
    @(negedge aclk);
    chk({tag, "_err_pulse"}, cfg_err, 0);
    chk({tag, "_busy"},      busy, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    aresetn = 1'b0; cfg_f1 = '0; cfg_f2 = '0; cfg_k = '0; cfg_nblk = '0;
    cfg_tvalid = 1'b0; abort = 1'b0; m_tready = 1'b1;

    // Reset state
    repeat (2) @(negedge aclk);
    chk("rst_tready", cfg_tready, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata",  m_tdata, 0);
    chk("rst_tuser",  m_tuser, 0);
    chk("rst_tlast",  m_tlast, 0);
    chk("rst_err",    cfg_err, 0);
    chk("rst_busy",   busy, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("idle_tready", cfg_tready, 1);
    chk("idle_state",  dbg_state, 0);

    // Single block, full throughput
    send_cfg(32'd3, 32'd10, 32'd40, 16'd1);
    check_init();
    collect(32'd40, 32'd3, 32'd10, 40, 1'b0);
    check_idle_after();

    // Same block with random back-pressure
    send_cfg(32'd3, 32'd10, 32'd40, 16'd1);
    check_init();
    collect(32'd40, 32'd3, 32'd10, 40, 1'b1);
    m_tready = 1'b1;
    check_idle_after();

    // Three repeated blocks, no gaps between them
    send_cfg(32'd3, 32'd10, 32'd40, 16'd3);
    check_init();
    collect(32'd40, 32'd3, 32'd10, 120, 1'b0);
    check_idle_after();

    // Invalid configurations
    check_bad("bad_k0",   32'd0,  32'd0,  32'd0,  16'd1);
    check_bad("bad_f1",   32'd40, 32'd10, 32'd40, 16'd1);
    check_bad("bad_f2",   32'd3,  32'd40, 32'd40, 16'd1);
    check_bad("bad_nblk", 32'd3,  32'd10, 32'd40, 16'd0);

    // K = 1: one beat that is both first and last
    send_cfg(32'd0, 32'd0, 32'd1, 16'd1);
    check_init();
    collect(32'd1, 32'd0, 32'd0, 1, 1'b0);
    check_idle_after();

    // Largest K, largest coefficients: first 100 indices, then abort
    send_cfg(32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 16'd1);
    check_init();
    collect(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 100, 1'b0);
    abort = 1'b1;
    @(negedge aclk);
    abort = 1'b0;
    #1;
    chk("bigk_abort_tvalid", m_tvalid, 0);
    chk("bigk_abort_busy",   busy, 0);

    // Abort at beat 17, then restart
    send_cfg(32'd3, 32'd10, 32'd40, 16'd1);
    m_tready = 1'b1;
    @(negedge aclk);
    repeat (17) @(negedge aclk);
    chk("abort_at_tid", m_tid, 17);
    abort = 1'b1;
    @(negedge aclk);
    abort = 1'b0;
    #1;
    chk("abort_tvalid", m_tvalid, 0);
    chk("abort_busy",   busy, 0);
    chk("abort_tready", cfg_tready, 1);
    send_cfg(32'd3, 32'd10, 32'd40, 16'd1);
    check_init();
    collect(32'd40, 32'd3, 32'd10, 40, 1'b0);
    check_idle_after();

    // Reset at beat 5, then restart
    send_cfg(32'd3, 32'd10, 32'd40, 16'd1);
    @(negedge aclk);
    repeat (5) @(negedge aclk);
    chk("reset_at_tid", m_tid, 5);
    #1 aresetn = 1'b0;
    #1;
    chk("midrst_tvalid", m_tvalid, 0);
    chk("midrst_tready", cfg_tready, 0);
    chk("midrst_busy",   busy, 0);
    chk("midrst_tdata",  m_tdata, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("midrst_idle_tready", cfg_tready, 1);
    send_cfg(32'd3, 32'd10, 32'd40, 16'd1);
    check_init();
    collect(32'd40, 32'd3, 32'd10, 40, 1'b0);
    check_idle_after();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the bench always ends on its own.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_qpp_index_gen
